// File: rtl/counter_axil_pkg.sv
// Shared constants, register map and helpers for the counter control/status block.
package counter_axil_pkg;

  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
  localparam int unsigned COUNT_W    = 8;

  // Register index taken from byte-address bits [3:2]
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_INIT   = 2'd2,
    REG_LOAD   = 2'd3
  } reg_sel_e;

  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_INIT   = 4'h8;
  localparam logic [3:0] OFS_LOAD   = 4'hC;

  localparam int unsigned CTRL_ENABLE_BIT  = 0;
  localparam int unsigned CTRL_DEC_BIT     = 1;
  localparam int unsigned STATUS_DONE_BIT  = 8;
  localparam int unsigned STATUS_ERROR_BIT = 9;
  localparam int unsigned INIT_WR_BIT      = 0;
  localparam int unsigned INIT_RD_BIT      = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
  } wr_payload_t;

  function automatic logic [AXI_DATA_W-1:0] strb_merge(
    input logic [AXI_DATA_W-1:0] old_word,
    input logic [AXI_DATA_W-1:0] new_word,
    input logic [AXI_STRB_W-1:0] strb
  );
    logic [AXI_DATA_W-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < AXI_STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_aw_w_join.sv
// Captures AXI-Lite AW and W independently, emits a joined write with a commit
// strobe, and owns the single-outstanding B handshake.
module axil_aw_w_join
  import counter_axil_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [AXI_DATA_W-1:0] wdata,
  input  logic [AXI_STRB_W-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic              bvalid,
  input  logic              bready,
  output logic              commit_c,
  output logic [ADDR_W-1:0] wr_addr,
  output wr_payload_t       wr_payload
);

  logic        live_q, live_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  wr_payload_t payload_q, payload_d;
  logic        aw_hs, w_hs;

  always_comb begin
    live_d    = 1'b1;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    bvalid_d  = bvalid_q;
    addr_d    = addr_q;
    payload_d = payload_q;

    aw_hs    = awvalid & awready_q;
    w_hs     = wvalid & wready_q;
    commit_c = aw_held_q & w_held_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      addr_d    = awaddr;
    end
    if (w_hs) begin
      w_held_d       = 1'b1;
      payload_d.data = wdata;
      payload_d.strb = wstrb;
    end
    if (commit_c) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
    end
    if (bvalid_q && bready) bvalid_d = 1'b0;

    // Readys reflect next-cycle state so they stay registered yet drop as soon as a channel is held
    awready_d = live_q & ~aw_held_d & ~bvalid_d;
    wready_d  = live_q & ~w_held_d & ~bvalid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q    <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      addr_q    <= '0;
      payload_q <= '0;
    end else begin
      live_q    <= live_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      addr_q    <= addr_d;
      payload_q <= payload_d;
    end
  end

  assign awready    = awready_q;
  assign wready     = wready_q;
  assign bvalid     = bvalid_q;
  assign wr_addr    = addr_q;
  assign wr_payload = payload_q;

endmodule

// File: rtl/counter_axil_regs.sv
// AXI4-Lite register block for the counter: CTRL, STATUS (sticky W1C), INIT pulses, LOAD.
module counter_axil_regs
  import counter_axil_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              ctrl_enable,
  output logic              ctrl_dec,
  output logic [DATA_W-1:0] load_value,
  output logic              init_wr_pulse,
  output logic              init_rd_pulse,
  input  logic [COUNT_W-1:0] count_in,
  input  logic              txn_done_in,
  input  logic              txn_error_in
);

  logic              commit_c;
  logic [ADDR_W-1:0] wr_addr;
  wr_payload_t       wr_payload;
  reg_sel_e          wr_sel;
  reg_sel_e          rd_sel;

  logic              live_q, live_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rd_word;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic              rd_pulse_q, rd_pulse_d;
  logic              ar_hs;
  logic              unused_c;

  axil_aw_w_join #(.ADDR_W(ADDR_W)) u_join (
    .clk        (aclk),
    .rst_n      (aresetn),
    .awaddr     (s_axi_awaddr),
    .awvalid    (s_axi_awvalid),
    .awready    (s_axi_awready),
    .wdata      (s_axi_wdata),
    .wstrb      (s_axi_wstrb),
    .wvalid     (s_axi_wvalid),
    .wready     (s_axi_wready),
    .bvalid     (s_axi_bvalid),
    .bready     (s_axi_bready),
    .commit_c   (commit_c),
    .wr_addr    (wr_addr),
    .wr_payload (wr_payload)
  );

  // Register file update; hardware set of sticky bits overrides a same-cycle W1C
  always_comb begin
    ctrl_d     = ctrl_q;
    load_d     = load_q;
    done_d     = done_q;
    err_d      = err_q;
    wr_pulse_d = 1'b0;
    rd_pulse_d = 1'b0;
    wr_sel     = reg_sel_e'(wr_addr[3:2]);

    if (commit_c) begin
      case (wr_sel)
        REG_CTRL: begin
          if (wr_payload.strb[0]) ctrl_d = wr_payload.data[1:0];
        end
        REG_STATUS: begin
          if (wr_payload.strb[1] && wr_payload.data[STATUS_DONE_BIT])  done_d = 1'b0;
          if (wr_payload.strb[1] && wr_payload.data[STATUS_ERROR_BIT]) err_d  = 1'b0;
        end
        REG_INIT: begin
          if (wr_payload.strb[0]) begin
            wr_pulse_d = wr_payload.data[INIT_WR_BIT];
            rd_pulse_d = wr_payload.data[INIT_RD_BIT];
          end
        end
        REG_LOAD: begin
          load_d = strb_merge(load_q, wr_payload.data, wr_payload.strb);
        end
      endcase
    end

    if (txn_done_in)  done_d = 1'b1;
    if (txn_error_in) err_d  = 1'b1;
  end

  // Read path: one outstanding read, data snapshotted at the AR handshake
  always_comb begin
    live_d   = 1'b1;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rd_word  = '0;
    rd_sel   = reg_sel_e'(s_axi_araddr[3:2]);
    ar_hs    = s_axi_arvalid & arready_q;

    case (rd_sel)
      REG_CTRL: rd_word[1:0] = ctrl_q;
      REG_STATUS: begin
        rd_word[COUNT_W-1:0]      = count_in;
        rd_word[STATUS_DONE_BIT]  = done_q;
        rd_word[STATUS_ERROR_BIT] = err_q;
      end
      REG_INIT: rd_word = '0;
      REG_LOAD: rd_word = load_q;
    endcase

    if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
    end
    arready_d = live_q & ~rvalid_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live_q     <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      ctrl_q     <= '0;
      load_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_pulse_q <= 1'b0;
      rd_pulse_q <= 1'b0;
    end else begin
      live_q     <= live_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RESP_OKAY;
  assign s_axi_bresp   = RESP_OKAY;
  assign ctrl_enable   = ctrl_q[CTRL_ENABLE_BIT];
  assign ctrl_dec      = ctrl_q[CTRL_DEC_BIT];
  assign load_value    = load_q;
  assign init_wr_pulse = wr_pulse_q;
  assign init_rd_pulse = rd_pulse_q;

  assign unused_c = ^{s_axi_awprot, s_axi_arprot, s_axi_araddr[1:0], wr_addr[1:0]};

endmodule

// File: tb/tb_counter_axil_regs.sv
// Directed scoreboard bench for counter_axil_regs.
module tb_counter_axil_regs;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata, load_value;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;
  logic        ctrl_enable, ctrl_dec, init_wr_pulse, init_rd_pulse;
  logic [7:0]  count_in;
  logic        txn_done_in, txn_error_in;

  int vectors = 0;
  int miscompares = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int b_rises = 0;
  logic bv_prev = 1'b0;

  logic [31:0] rq[$];
  string       rtag[$];
  logic [1:0]  bq[$];

  counter_axil_regs #(.ADDR_W(4), .DATA_W(32)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .ctrl_enable   (ctrl_enable),
    .ctrl_dec      (ctrl_dec),
    .load_value    (load_value),
    .init_wr_pulse (init_wr_pulse),
    .init_rd_pulse (init_rd_pulse),
    .count_in      (count_in),
    .txn_done_in   (txn_done_in),
    .txn_error_in  (txn_error_in)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Count pulse-high cycles and bvalid rising edges mid-cycle
  always @(negedge aclk) begin
    if (init_wr_pulse) wr_pulses++;
    if (init_rd_pulse) rd_pulses++;
    if (bvalid && !bv_prev) b_rises++;
    bv_prev = bvalid;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, 32'(obs), 32'(exp));
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input logic done_at_commit);
    int   n;
    logic aw_hs, w_hs;
    bq.push_back(2'b00);
    bready = 1'b1;
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    for (int i = 0; i < w_lead; i++) begin
      w_hs = wvalid & wready;
      tick();
      if (w_hs) wvalid = 1'b0;
    end
    if (w_lead > 0) begin
      check1("no_commit_before_aw", bvalid, 1'b0);
      check1("wready_low_while_w_held", wready, 1'b0);
    end
    awaddr  = a;
    awvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid & awready;
      w_hs  = wvalid & wready;
      tick();
      n++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    check("aw_w_accept_in_time", 32'(n < 20), 32'd1);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    txn_done_in = done_at_commit;
    tick();
    txn_done_in = 1'b0;
    n = 0;
    while (!bvalid && n < 10) begin
      tick();
      n++;
    end
    check1("bvalid_in_time", bvalid, 1'b1);
    check("bresp", 32'(bresp), 32'(bq.pop_front()));
    tick();
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
    int n;
    rq.push_back(exp);
    rtag.push_back(tag);
    rready  = 1'b1;
    araddr  = a;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 10) begin
      tick();
      n++;
    end
    tick();
    arvalid = 1'b0;
    check1("rvalid_in_time", rvalid, 1'b1);
    check(rtag.pop_front(), rdata, rq.pop_front());
    check("rresp", 32'(rresp), 32'd0);
    tick();
  endtask

  initial begin
    int b0, w0, r0;
    aresetn = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0;
    bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    count_in = '0; txn_done_in = 1'b0; txn_error_in = 1'b0;
    #3;

    // Reset state
    check1("rst_awready", awready, 1'b0);
    check1("rst_wready", wready, 1'b0);
    check1("rst_arready", arready, 1'b0);
    check1("rst_bvalid", bvalid, 1'b0);
    check1("rst_rvalid", rvalid, 1'b0);
    check1("rst_enable", ctrl_enable, 1'b0);
    check1("rst_dec", ctrl_dec, 1'b0);
    check("rst_load", load_value, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check1("rst_wr_pulse", init_wr_pulse, 1'b0);
    check1("rst_rd_pulse", init_rd_pulse, 1'b0);

    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    tick();
    check1("awready_first_edge", awready, 1'b0);
    check1("arready_first_edge", arready, 1'b0);
    tick();
    check1("awready_second_edge", awready, 1'b1);
    check1("wready_second_edge", wready, 1'b1);
    check1("arready_second_edge", arready, 1'b1);

    // CTRL write with AW and W together
    axi_write(4'h0, 32'h1, 4'hF, 0, 1'b0);
    check1("ctrl_enable_set", ctrl_enable, 1'b1);
    check1("ctrl_dec_clear", ctrl_dec, 1'b0);
    axi_read(4'h0, 32'h1, "rd_ctrl");

    // W leads AW by three cycles
    b0 = b_rises;
    axi_write(4'hC, 32'hAF, 4'hF, 3, 1'b0);
    check("load_after_late_aw", load_value, 32'hAF);
    check("single_bvalid", 32'(b_rises - b0), 32'd1);

    // Byte strobes on CTRL and LOAD; address bits [1:0] ignored
    axi_write(4'h0, 32'h2, 4'b1110, 0, 1'b0);
    check1("ctrl_strb_masked_en", ctrl_enable, 1'b1);
    check1("ctrl_strb_masked_dec", ctrl_dec, 1'b0);
    axi_write(4'hC, 32'h1234_5678, 4'b0101, 0, 1'b0);
    check("load_strb_merge", load_value, 32'h0034_0078);
    axi_read(4'hF, 32'h0034_0078, "rd_load_lsb_ignored");

    // INIT pulses
    w0 = wr_pulses; r0 = rd_pulses;
    axi_write(4'h8, 32'h2, 4'hF, 0, 1'b0);
    check("init_rd_pulse_once", 32'(rd_pulses - r0), 32'd1);
    check("init_wr_pulse_none", 32'(wr_pulses - w0), 32'd0);
    w0 = wr_pulses; r0 = rd_pulses;
    axi_write(4'h8, 32'h3, 4'b1110, 0, 1'b0);
    check("init_strb_masked", 32'((rd_pulses - r0) + (wr_pulses - w0)), 32'd0);
    w0 = wr_pulses; r0 = rd_pulses;
    axi_write(4'h8, 32'h3, 4'hF, 0, 1'b0);
    check("init_both_rd", 32'(rd_pulses - r0), 32'd1);
    check("init_both_wr", 32'(wr_pulses - w0), 32'd1);
    axi_read(4'h8, 32'h0, "rd_init_zero");

    // STATUS sticky bits and W1C
    count_in = 8'hB3;
    txn_done_in = 1'b1;
    tick();
    txn_done_in = 1'b0;
    axi_read(4'h4, 32'h1B3, "rd_status_done");
    axi_write(4'h4, 32'h100, 4'hF, 0, 1'b0);
    axi_read(4'h4, 32'h0B3, "rd_status_cleared");
    axi_write(4'h4, 32'h100, 4'hF, 0, 1'b1);
    axi_read(4'h4, 32'h1B3, "rd_status_set_wins");
    txn_error_in = 1'b1;
    tick();
    txn_error_in = 1'b0;
    count_in = 8'h5A;
    axi_read(4'h4, 32'h35A, "rd_status_both");
    axi_write(4'h4, 32'h300, 4'b0001, 0, 1'b0);
    axi_read(4'h4, 32'h35A, "rd_status_w1c_strb_masked");
    axi_write(4'h4, 32'h300, 4'b0010, 0, 1'b0);
    axi_read(4'h4, 32'h05A, "rd_status_w1c_both");

    // Backpressure on B: second AW must wait
    bq.push_back(2'b00);
    bready = 1'b0;
    awaddr = 4'h0; wdata = 32'h3; wstrb = 4'hF;
    check1("awready_before_hold", awready, 1'b1);
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    awaddr = 4'hC;
    awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check1("bvalid_held", bvalid, 1'b1);
      check1("awready_low_bvalid", awready, 1'b0);
      check1("wready_low_bvalid", wready, 1'b0);
      tick();
    end
    check("bresp_held", 32'(bresp), 32'(bq.pop_front()));
    bready = 1'b1;
    tick();
    check1("bvalid_dropped", bvalid, 1'b0);
    check1("awready_after_b", awready, 1'b1);
    check1("ctrl_dec_set", ctrl_dec, 1'b1);
    axi_write(4'hC, 32'h55, 4'hF, 0, 1'b0);
    check("load_second_write", load_value, 32'h55);

    // Reset asserted while rvalid is held
    rq.push_back(32'h55);
    rready = 1'b0;
    araddr = 4'hC;
    check1("arready_before_rst_read", arready, 1'b1);
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check1("rvalid_before_rst", rvalid, 1'b1);
    check("rdata_before_rst", rdata, rq.pop_front());
    #2;
    aresetn = 1'b0;
    #1;
    check1("rst_mid_rvalid", rvalid, 1'b0);
    check1("rst_mid_enable", ctrl_enable, 1'b0);
    check("rst_mid_load", load_value, 32'h0);
    check1("rst_mid_arready", arready, 1'b0);
    tick();
    aresetn = 1'b1;
    tick();
    check1("arready_rel_edge1", arready, 1'b0);
    check1("awready_rel_edge1", awready, 1'b0);
    tick();
    check1("arready_rel_edge2", arready, 1'b1);
    check1("awready_rel_edge2", awready, 1'b1);
    axi_read(4'h0, 32'h0, "rd_ctrl_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
